button_event_fsm: RTL and testbench

- Sits directly downstream of the button debouncer; consumes one debounced, clk-domain button level.
- Converts that level into single-cycle event pulses for the control logic: press, release, short click, long press and auto-repeat.
- One instance per debounced button.

---
 rtl/button_event_fsm_pkg.sv | 17 +
 rtl/button_event_fsm.sv | 127 ++++++++++++
 tb/tb_button_event_fsm.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/button_event_fsm_pkg.sv
// Shared types and default timing for the button event FSM.
// Defaults assume the 100 MHz board clock: 0.5 s long press, 0.1 s repeat period.
package button_event_fsm_pkg;

  typedef enum logic [1:0] {
    ST_LOCKOUT = 2'd0,
    ST_IDLE    = 2'd1,
    ST_PRESSED = 2'd2,
    ST_HELD    = 2'd3
  } state_t;

  localparam int CLK_HZ             = 100_000_000;
  localparam int DEF_LONG_CYCLES    = CLK_HZ / 2;
  localparam int DEF_REPEAT_CYCLES  = CLK_HZ / 10;
  localparam int DEF_CNT_W          = 26;

endpackage

// File: rtl/button_event_fsm.sv
// Turns one debounced button level into registered press/release/click/long/repeat pulses.
// One FSM plus one down-bounded up-counter that is reused for the long and repeat timers.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_LOCKOUT | after reset; waits for btn_in=0 so a held button is ignored
// ST_IDLE    | released, waiting for a press
// ST_PRESSED | pressed, counting toward the long-press threshold
// ST_HELD    | long press reported, counter paces the auto-repeat
module button_event_fsm
  import button_event_fsm_pkg::*;
#(
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic repeat_en,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CYCLES - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  logic r_press, r_release, r_click, r_long, r_repeat, r_held;
  logic w_press, w_release, w_click, w_long, w_repeat, w_held;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_LOCKOUT;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_click   <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_press   <= w_press;
      r_release <= w_release;
      r_click   <= w_click;
      r_long    <= w_long;
      r_repeat  <= w_repeat;
      r_held    <= w_held;
    end
  end

  // Release is tested before the terminal counts so it wins a same-edge tie.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press     = 1'b0;
    w_release   = 1'b0;
    w_click     = 1'b0;
    w_long      = 1'b0;
    w_repeat    = 1'b0;

    case (r_state)
      ST_LOCKOUT: begin
        w_cnt_nxt = '0;
        if (!btn_in) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (btn_in) begin
          w_state_nxt = ST_PRESSED;
          w_press     = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!btn_in) begin
          w_state_nxt = ST_IDLE;
          w_release   = 1'b1;
          w_click     = 1'b1;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LONG_TC) begin
          w_state_nxt = ST_HELD;
          w_long      = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_HELD: begin
        if (!btn_in) begin
          w_state_nxt = ST_IDLE;
          w_release   = 1'b1;
          w_cnt_nxt   = '0;
        end else if (r_cnt == REP_TC) begin
          // Wraps even with repeat disabled so the repeat phase stays tied to the long edge.
          w_cnt_nxt = '0;
          w_repeat  = repeat_en;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_LOCKOUT;
        w_cnt_nxt   = '0;
      end
    endcase

    w_held = (w_state_nxt == ST_PRESSED) || (w_state_nxt == ST_HELD);
  end

  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign click_pulse   = r_click;
  assign long_pulse    = r_long;
  assign repeat_pulse  = r_repeat;
  assign held          = r_held;

endmodule

// File: tb/tb_button_event_fsm.sv
// Scoreboard bench for button_event_fsm with LONG_CYCLES=5, REPEAT_CYCLES=3.
// Stimulus pushes {edge, expected outputs}; the monitor pops whenever that edge's outputs appear.
module tb_button_event_fsm;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_in = 1'b0;
  logic repeat_en = 1'b0;
  logic press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held;

  button_event_fsm #(
    .LONG_CYCLES  (5),
    .REPEAT_CYCLES(3),
    .CNT_W        (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .repeat_en    (repeat_en),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .click_pulse  (click_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held)
  );

  always #5 clk = ~clk;

  // Output vector order: {press, release, click, long, repeat, held}
  localparam logic [5:0] V_P  = 6'b100001;
  localparam logic [5:0] V_L  = 6'b000101;
  localparam logic [5:0] V_R  = 6'b000011;
  localparam logic [5:0] V_RC = 6'b011000;
  localparam logic [5:0] V_RL = 6'b010000;
  localparam logic [5:0] V_N  = 6'b000000;

  typedef struct {
    int         cyc;
    logic [5:0] vec;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  int   held_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] outs();
    return {press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held};
  endfunction

  always @(negedge clk) begin
    logic [5:0] act;
    exp_t       e;
    if (!rst) begin
      act = outs();
      if (held) held_cnt++;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        n_total++;
        $display("FAIL missed_event edge=%0d got=nothing expected=%b", e.cyc, e.vec);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        n_total++;
        if (act === e.vec) n_pass++;
        else $display("FAIL event edge=%0d got=%b expected=%b", cyc, act, e.vec);
      end else if (act[5:1] != 5'b0) begin
        n_total++;
        $display("FAIL unexpected_pulse edge=%0d got=%b expected=no pulse", cyc, act);
      end
    end
  end

  // Drive inputs right after a negedge; they are sampled at edge cyc+1.
  task automatic step(input logic b, input logic e, input logic [5:0] v);
    if (v[5:1] != 5'b0) q.push_back('{cyc + 1, v});
    btn_in    = b;
    repeat_en = e;
    @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d", name, act, exp);
  endtask

  task automatic hold_for(input int n, input logic e);
    for (int i = 0; i < n; i++) step(1'b1, e, V_N);
  endtask

  task automatic idle_for(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, V_N);
  endtask

  initial begin
    // Button held through reset never produces events.
    btn_in = 1'b1;
    #2 rst = 1'b1;
    #2 check("reset_outputs", int'(outs()), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    held_cnt = 0;
    hold_for(20, 1'b1);
    check("lockout_held_cycles", held_cnt, 0);
    idle_for(3);
    // Minimum-length press: press then click+release on consecutive edges.
    step(1'b1, 1'b0, V_P);
    step(1'b0, 1'b0, V_RC);
    idle_for(3);

    // Three-cycle press.
    held_cnt = 0;
    step(1'b1, 1'b0, V_P);
    hold_for(2, 1'b0);
    step(1'b0, 1'b0, V_RC);
    idle_for(3);
    check("short_press_held_cycles", held_cnt, 3);

    // Long press with repeat enabled: long at E5, repeat at E8/E11/E14, release only at E15.
    step(1'b1, 1'b1, V_P);
    for (int k = 1; k <= 14; k++)
      step(1'b1, 1'b1, (k == 5) ? V_L : ((k == 8 || k == 11 || k == 14) ? V_R : V_N));
    step(1'b0, 1'b1, V_RL);
    idle_for(3);

    // Repeat disabled until E10: no repeat at E8, repeats resume in phase at E11 and E14.
    step(1'b1, 1'b0, V_P);
    for (int k = 1; k <= 14; k++)
      step(1'b1, (k >= 10), (k == 5) ? V_L : ((k == 11 || k == 14) ? V_R : V_N));
    step(1'b0, 1'b0, V_RL);
    idle_for(3);

    // Release sampled exactly on the long-press edge: click wins.
    held_cnt = 0;
    step(1'b1, 1'b0, V_P);
    hold_for(4, 1'b0);
    step(1'b0, 1'b0, V_RC);
    idle_for(3);
    check("tie_release_held_cycles", held_cnt, 5);

    // Reset asynchronously during HELD at E7, button kept down across reset.
    step(1'b1, 1'b0, V_P);
    for (int k = 1; k <= 6; k++) step(1'b1, 1'b0, (k == 5) ? V_L : V_N);
    check("held_before_reset", int'(held), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("async_reset_outputs", int'(outs()), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    held_cnt = 0;
    hold_for(10, 1'b1);
    check("post_reset_lockout_held", held_cnt, 0);
    idle_for(2);
    step(1'b1, 1'b0, V_P);
    step(1'b1, 1'b0, V_N);
    step(1'b0, 1'b0, V_RC);
    idle_for(3);

    check("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
